// File: rtl/gpio_cfg_serial_loader.sv
// GPIO configuration shift-chain transmitter: holds one word per pad, serializes the
// whole chain (farthest pad first, MSB first) and then strobes load so every pad latches.
module gpio_cfg_serial_loader #(
  parameter int unsigned NUM_PADS = 38,
  parameter int unsigned CFG_BITS = 13,
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [31:0] CFG_INIT = 32'h0000_0403
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cfg_we,
  input  logic [5:0]          cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                wr_err,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                serial_resetn
);

  localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [PAD_W-1:0]    PAD_TOP   = PAD_W'(NUM_PADS - 1);
  localparam logic [BIT_W-1:0]    BIT_TOP   = BIT_W'(CFG_BITS - 1);
  localparam logic [CFG_BITS-1:0] INIT_WORD = CFG_INIT[CFG_BITS-1:0];

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHIFT_LO = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

  logic [2:0]          r_state;
  logic [PAD_W-1:0]    r_pad;
  logic [BIT_W-1:0]    r_bit;
  logic [DIV_W-1:0]    r_div;
  logic [CFG_BITS-1:0] r_word [NUM_PADS];
  logic                r_wr_err;
  logic                r_resetn;

  logic             w_addr_ok;
  logic [PAD_W-1:0] w_idx;
  logic             w_busy;
  logic             w_shifting;
  logic             w_phase_end;
  logic             w_last_bit;

  assign w_addr_ok   = (32'(cfg_addr) < NUM_PADS);
  assign w_idx       = cfg_addr[PAD_W-1:0];
  assign w_shifting  = (r_state == S_SHIFT_LO) || (r_state == S_SHIFT_HI);
  assign w_busy      = w_shifting || (r_state == S_LOAD);
  assign w_phase_end = (r_div == DIV_LAST);
  assign w_last_bit  = (r_pad == '0) && (r_bit == '0);

  assign cfg_rdata     = w_addr_ok ? r_word[w_idx] : '0;
  assign busy          = w_busy;
  assign done          = (r_state == S_FINISH);
  assign wr_err        = r_wr_err;
  assign serial_clock  = (r_state == S_SHIFT_HI);
  assign serial_load   = (r_state == S_LOAD);
  // Words are read live; writes are locked out while shifting, so no snapshot is needed.
  assign serial_data   = w_shifting ? r_word[r_pad][r_bit] : 1'b0;
  assign serial_resetn = r_resetn;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(NUM_PADS); i++) begin
        r_word[i] <= INIT_WORD;
      end
    end else if (cfg_we && !w_busy && w_addr_ok) begin
      r_word[w_idx] <= cfg_wdata;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    r_resetn <= !wb_rst_i;
    if (wb_rst_i) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= (cfg_we && w_busy) || (start && (w_busy || (r_state == S_FINISH)));
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_pad   <= '0;
      r_bit   <= '0;
      r_div   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SHIFT_LO;
            r_pad   <= PAD_TOP;
            r_bit   <= BIT_TOP;
            r_div   <= '0;
          end
        end
        S_SHIFT_LO: begin
          if (w_phase_end) begin
            r_div   <= '0;
            r_state <= S_SHIFT_HI;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (w_phase_end) begin
            r_div <= '0;
            if (w_last_bit) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_SHIFT_LO;
              // Step to the next pad's MSB once the current word is exhausted.
              if (r_bit == '0) begin
                r_bit <= BIT_TOP;
                r_pad <= r_pad - 1'b1;
              end else begin
                r_bit <= r_bit - 1'b1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_LOAD: begin
          if (w_phase_end) begin
            r_div   <= '0;
            r_state <= S_FINISH;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Scoreboard bench for gpio_cfg_serial_loader: two instances (CLK_DIV=1 and CLK_DIV=3)
// share stimulus; per-instance monitors pop expected serial bits on each serial_clock rise.
module tb_gpio_cfg_serial_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, we, start;
  logic [5:0] addr;
  logic [3:0] wdata;

  logic [3:0] rdata1, rdata3;
  logic busy1, done1, err1, sclk1, sdata1, load1, rstn1;
  logic busy3, done3, err3, sclk3, sdata3, load3, rstn3;

  int n_chk = 0;
  int n_fail = 0;
  bit q1[$];
  bit q3[$];

  gpio_cfg_serial_loader #(
    .NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(1), .CFG_INIT(32'h0000_0403)
  ) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata),
    .cfg_rdata(rdata1), .start(start), .busy(busy1), .done(done1), .wr_err(err1),
    .serial_clock(sclk1), .serial_data(sdata1), .serial_load(load1), .serial_resetn(rstn1)
  );

  gpio_cfg_serial_loader #(
    .NUM_PADS(2), .CFG_BITS(4), .CLK_DIV(3), .CFG_INIT(32'h0000_0403)
  ) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata),
    .cfg_rdata(rdata3), .start(start), .busy(busy3), .done(done3), .wr_err(err3),
    .serial_clock(sclk3), .serial_data(sdata3), .serial_load(load3), .serial_resetn(rstn3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic prev1 = 1'b0;
  always @(negedge clk) begin
    bit e;
    if (sclk1 && !prev1) begin
      if (q1.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sdata1: unexpected shift edge, got bit %0b expected none", sdata1);
      end else begin
        e = q1.pop_front();
        check("sdata1", 64'(sdata1), 64'(e));
      end
    end
    prev1 = sclk1;
  end

  logic prev3 = 1'b0;
  always @(negedge clk) begin
    bit e;
    if (sclk3 && !prev3) begin
      if (q3.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sdata3: unexpected shift edge, got bit %0b expected none", sdata3);
      end else begin
        e = q3.pop_front();
        check("sdata3", 64'(sdata3), 64'(e));
      end
    end
    prev3 = sclk3;
  end

  // One full frame: expected bits go to both scoreboards, timing is measured per cycle.
  task automatic run_frame(input string tag, input logic [3:0] w1, input logic [3:0] w0,
                           input bit err_inj, input bit wr_same, input logic [3:0] wr_val);
    logic [63:0] bm1, bm3, lm1, lm3, em1, em3;
    int d1, d3, dc1, dc3, sf1, sf3, sc1, sc3;
    bm1 = '0; bm3 = '0; lm1 = '0; lm3 = '0; em1 = '0; em3 = '0;
    d1 = 0; d3 = 0; dc1 = 0; dc3 = 0; sf1 = 0; sf3 = 0; sc1 = 0; sc3 = 0;
    for (int b = 3; b >= 0; b--) begin
      q1.push_back(w1[b]);
      q3.push_back(w1[b]);
    end
    for (int b = 3; b >= 0; b--) begin
      q1.push_back(w0[b]);
      q3.push_back(w0[b]);
    end
    if (wr_same) begin
      we = 1'b1; addr = 6'd1; wdata = wr_val;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; we = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (err_inj && k == 4) begin
        we = 1'b1; addr = 6'd0; wdata = 4'hF;
      end
      if (err_inj && k == 8) start = 1'b1;
      @(negedge clk);
      if (busy1) bm1[k] = 1'b1;
      if (busy3) bm3[k] = 1'b1;
      if (load1) lm1[k] = 1'b1;
      if (load3) lm3[k] = 1'b1;
      if (err1) em1[k] = 1'b1;
      if (err3) em3[k] = 1'b1;
      if (done1) begin dc1++; if (d1 == 0) d1 = k; end
      if (done3) begin dc3++; if (d3 == 0) d3 = k; end
      if (sclk1) begin sc1++; if (sf1 == 0) sf1 = k; end
      if (sclk3) begin sc3++; if (sf3 == 0) sf3 = k; end
      @(posedge clk); #1;
      we = 1'b0; start = 1'b0;
    end
    check({tag, "_done1_cycle"}, 64'(d1), 64'd18);
    check({tag, "_done3_cycle"}, 64'(d3), 64'd52);
    check({tag, "_done1_count"}, 64'(dc1), 64'd1);
    check({tag, "_done3_count"}, 64'(dc3), 64'd1);
    check({tag, "_busy1_mask"}, bm1, ((64'd1 << 18) - 64'd1) & ~64'd1);
    check({tag, "_busy3_mask"}, bm3, ((64'd1 << 52) - 64'd1) & ~64'd1);
    check({tag, "_load1_mask"}, lm1, 64'd1 << 17);
    check({tag, "_load3_mask"}, lm3, 64'd7 << 49);
    check({tag, "_sclk1_first"}, 64'(sf1), 64'd2);
    check({tag, "_sclk1_cycles"}, 64'(sc1), 64'd8);
    check({tag, "_sclk3_first"}, 64'(sf3), 64'd4);
    check({tag, "_sclk3_cycles"}, 64'(sc3), 64'd24);
    check({tag, "_err1_mask"}, em1, err_inj ? ((64'd1 << 5) | (64'd1 << 9)) : 64'd0);
    check({tag, "_err3_mask"}, em3, err_inj ? ((64'd1 << 5) | (64'd1 << 9)) : 64'd0);
    check({tag, "_q1_drained"}, 64'(q1.size()), 64'd0);
    check({tag, "_q3_drained"}, 64'(q3.size()), 64'd0);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; we = 1'b0; start = 1'b0; addr = 6'd0; wdata = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_wr_err", 64'(err1), 64'd0);
    check("rst_sclk", 64'(sclk1), 64'd0);
    check("rst_sdata", 64'(sdata1), 64'd0);
    check("rst_load", 64'(load1), 64'd0);
    check("rst_resetn", 64'(rstn1), 64'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_resetn_low", 64'(rstn1), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("release_resetn1_high", 64'(rstn1), 64'd1);
    check("release_resetn3_high", 64'(rstn3), 64'd1);

    addr = 6'd0; #1;
    check("rd_init_a0", 64'(rdata1), 64'h3);
    check("rd3_init_a0", 64'(rdata3), 64'h3);
    addr = 6'd1; #1;
    check("rd_init_a1", 64'(rdata1), 64'h3);
    addr = 6'd5; #1;
    check("rd_oob_a5", 64'(rdata1), 64'h0);

    @(posedge clk); #1;
    we = 1'b1; addr = 6'd1; wdata = 4'hA;
    @(posedge clk); #1;
    addr = 6'd0; wdata = 4'h5;
    @(posedge clk); #1;
    addr = 6'd5; wdata = 4'hC;
    @(posedge clk); #1;
    we = 1'b0;
    addr = 6'd1; #1;
    check("rd_w1", 64'(rdata1), 64'hA);
    addr = 6'd0; #1;
    check("rd_w0", 64'(rdata1), 64'h5);
    addr = 6'd5; #1;
    check("rd_oob_after_write", 64'(rdata1), 64'h0);

    run_frame("f1", 4'hA, 4'h5, 1'b0, 1'b0, 4'h0);
    run_frame("f2err", 4'hA, 4'h5, 1'b1, 1'b0, 4'h0);
    addr = 6'd0; #1;
    check("rd_w0_after_reject", 64'(rdata1), 64'h5);
    check("rd3_w0_after_reject", 64'(rdata3), 64'h5);

    // Abort during the first bit's high phase on the CLK_DIV=1 instance.
    q1.push_back(1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy1", 64'(busy1), 64'd0);
    check("abort_sclk1", 64'(sclk1), 64'd0);
    check("abort_sdata1", 64'(sdata1), 64'd0);
    check("abort_load1", 64'(load1), 64'd0);
    check("abort_resetn1", 64'(rstn1), 64'd0);
    check("abort_busy3", 64'(busy3), 64'd0);
    check("abort_sclk3", 64'(sclk3), 64'd0);
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done1 || done3) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    check("abort_resetn_back", 64'(rstn1), 64'd1);
    check("abort_q1_drained", 64'(q1.size()), 64'd0);
    addr = 6'd0; #1;
    check("abort_rd_a0", 64'(rdata1), 64'h3);
    addr = 6'd1; #1;
    check("abort_rd_a1", 64'(rdata1), 64'h3);

    run_frame("f3", 4'h3, 4'h3, 1'b0, 1'b0, 4'h0);
    run_frame("f4same", 4'h8, 4'h3, 1'b0, 1'b1, 4'h8);
    addr = 6'd1; #1;
    check("rd_same_cycle_w1", 64'(rdata1), 64'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
